// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: sawtooth counter plus a reference that slews toward a
// host-loaded target by one LSB per STEP_PERIODS PWM periods. The reference
// only moves on a period boundary, so the comparator never sees a glitch.
module pwm_ramp_ctrl #(
  parameter int WIDTH        = 4,
  parameter int PRESC_W      = 8,
  parameter int STEP_PERIODS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en_i,
  input  logic [PRESC_W-1:0] presc_i,
  input  logic [WIDTH-1:0]   target_i,
  input  logic               load_i,
  output logic [WIDTH-1:0]   cont_o,
  output logic [WIDTH-1:0]   ref_o,
  output logic               wrap_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int PCNT_W = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(STEP_PERIODS - 1);

  typedef enum logic {IDLE = 1'b0, RAMP = 1'b1} state_t;

  state_t             r_state, w_next;
  logic [PRESC_W-1:0] r_presc;
  logic [WIDTH-1:0]   r_cont, r_ref, r_tgt;
  logic [PCNT_W-1:0]  r_pcnt;
  logic               r_wrap, r_done;
  logic               w_tick, w_wrap_ev, w_step, w_done_ev;

  // >= (not ==) so that lowering presc_i below the running count ticks at once
  assign w_tick    = en_i && (r_presc >= presc_i);
  assign w_wrap_ev = w_tick && (r_cont == {WIDTH{1'b1}});
  assign w_step    = w_wrap_ev && (r_state == RAMP) && (r_pcnt == PCNT_LAST);

  // Prescaler: free-runs while enabled, clears on each tick
  always_ff @(posedge clk) begin
    if (reset)     r_presc <= '0;
    else if (en_i) r_presc <= w_tick ? '0 : r_presc + PRESC_W'(1);
  end

  // Sawtooth counter; wrap pulse is registered so it lines up with cont_o==0
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cont <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_wrap_ev;
      if (w_tick) r_cont <= r_cont + WIDTH'(1);
    end
  end

  // Target capture; accepted regardless of en_i
  always_ff @(posedge clk) begin
    if (reset)       r_tgt <= '0;
    else if (load_i) r_tgt <= target_i;
  end

  // Reference slews one LSB toward the target on a step event only
  always_ff @(posedge clk) begin
    if (reset) r_ref <= '0;
    else if (w_step) begin
      if (r_ref < r_tgt)      r_ref <= r_ref + WIDTH'(1);
      else if (r_ref > r_tgt) r_ref <= r_ref - WIDTH'(1);
    end
  end

  // Period counter: counts wraps in RAMP, cleared when falling back to IDLE
  always_ff @(posedge clk) begin
    if (reset) r_pcnt <= '0;
    else if (r_state == RAMP && w_next == IDLE) r_pcnt <= '0;
    else if (r_state == RAMP && w_wrap_ev)
      r_pcnt <= (r_pcnt == PCNT_LAST) ? '0 : r_pcnt + PCNT_W'(1);
  end

  // FSM state register and registered done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_done_ev;
    end
  end

  // Next-state: ramp while target and reference differ; frozen when disabled
  always_comb begin
    w_next    = r_state;
    w_done_ev = 1'b0;
    if (en_i) begin
      case (r_state)
        IDLE: if (r_tgt != r_ref) w_next = RAMP;
        RAMP: if (r_tgt == r_ref) begin
          w_next    = IDLE;
          w_done_ev = 1'b1;
        end
        default: w_next = IDLE;
      endcase
    end
  end

  assign cont_o = r_cont;
  assign ref_o  = r_ref;
  assign wrap_o = r_wrap;
  assign busy_o = (r_state == RAMP);
  assign done_o = r_done;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: a vector table for counter/prescaler
// behaviour, then hand-written sequences for the ramp corner cases.
module tb_pwm_ramp_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       en_i;
  logic [7:0] presc_i;
  logic [3:0] target_i;
  logic       load_i;
  logic [3:0] cont_o, ref_o;
  logic       wrap_o, busy_o, done_o;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       en;
    logic [7:0] presc;
    logic [3:0] exp_cont;
    logic       exp_wrap;
  } vec_t;

  vec_t tbl[$];

  pwm_ramp_ctrl #(.WIDTH(4), .PRESC_W(8), .STEP_PERIODS(4)) dut (
    .clk(clk), .reset(reset), .en_i(en_i), .presc_i(presc_i),
    .target_i(target_i), .load_i(load_i), .cont_o(cont_o), .ref_o(ref_o),
    .wrap_o(wrap_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input logic en, input logic [7:0] presc, input int c, input logic w);
    vec_t v;
    v.en = en; v.presc = presc; v.exp_cont = 4'(c); v.exp_wrap = w;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    reset = 1'b1; en_i = 1'b0; load_i = 1'b0; presc_i = 8'd0; target_i = 4'd0;
    step();
    reset = 1'b0;
  endtask

  task automatic do_load(input logic [3:0] t);
    load_i = 1'b1; target_i = t;
    step();
    load_i = 1'b0;
  endtask

  // Step until ref_o changes; the change must coincide with wrap_o after
  // exp_wraps wraps, with no done pulse along the way.
  task automatic wait_step(input string nm, input int exp_ref, input int exp_wraps);
    int wraps, ndone;
    logic [3:0] r0;
    bit ok;
    wraps = 0; ndone = 0; ok = 0; r0 = ref_o;
    for (int c = 0; c < 200; c++) begin
      step();
      if (wrap_o) wraps++;
      if (done_o) ndone++;
      if (ref_o != r0) begin
        ok = 1;
        check({nm, "_wrap"}, wrap_o, 1);
        check({nm, "_ref"}, ref_o, exp_ref);
        check({nm, "_nwrap"}, wraps, exp_wraps);
        break;
      end
    end
    check({nm, "_done"}, ndone, 0);
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: got no ref change expected ref %0d", nm, exp_ref);
    end
  endtask

  task automatic wait_wraps(input string nm, input int n);
    int wraps;
    wraps = 0;
    for (int c = 0; c < 20 * n + 40 && wraps < n; c++) begin
      step();
      if (wrap_o) wraps++;
    end
    if (wraps < n) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: got %0d wraps expected %0d", nm, wraps, n);
    end
  endtask

  // Cycle after the final step: still busy, then one done pulse with busy low
  task automatic finish_ramp(input string nm);
    check({nm, "_busy_hold"}, busy_o, 1);
    check({nm, "_done_early"}, done_o, 0);
    step();
    check({nm, "_done"}, done_o, 1);
    check({nm, "_busy_off"}, busy_o, 0);
    step();
    check({nm, "_done_once"}, done_o, 0);
  endtask

  initial begin
    int cyc;
    logic [3:0] c0, r0;

    // Vector table: counter at presc 0, presc 2, presc lowered on the fly, en=0
    for (int k = 1; k <= 17; k++) add(1'b1, 8'd0, k % 16, k == 16);
    add(1, 2, 1, 0); add(1, 2, 1, 0); add(1, 2, 2, 0);
    add(1, 2, 2, 0); add(1, 2, 2, 0); add(1, 2, 3, 0);
    add(1, 2, 3, 0); add(1, 2, 3, 0); add(1, 0, 4, 0); add(1, 0, 5, 0);
    add(1, 2, 5, 0); add(1, 0, 6, 0); add(1, 0, 7, 0);
    add(0, 0, 7, 0); add(0, 0, 7, 0); add(1, 0, 8, 0);

    // Reset state
    do_reset();
    check("rst_cont", cont_o, 0);
    check("rst_ref", ref_o, 0);
    check("rst_wrap", wrap_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);

    foreach (tbl[i]) begin
      en_i = tbl[i].en; presc_i = tbl[i].presc;
      step();
      check($sformatf("vec%0d_cont", i), cont_o, tbl[i].exp_cont);
      check($sformatf("vec%0d_wrap", i), wrap_o, tbl[i].exp_wrap);
      check($sformatf("vec%0d_ref", i), ref_o, 0);
      check($sformatf("vec%0d_busy", i), busy_o, 0);
    end

    // Wrap period with presc_i=2 is 48 clocks
    presc_i = 8'd2;
    wait_wraps("t2_first", 1);
    cyc = 0;
    for (int c = 0; c < 100; c++) begin
      step(); cyc++;
      if (wrap_o) break;
    end
    check("t2_wrap_period", cyc, 48);

    // Ramp 0 -> 3, load-to-busy latency 2
    do_reset();
    en_i = 1'b1; presc_i = 8'd0;
    do_load(4'd3);
    check("t3_busy_lat1", busy_o, 0);
    step();
    check("t3_busy_lat2", busy_o, 1);
    wait_step("t3_s1", 1, 4);
    wait_step("t3_s2", 2, 4);
    wait_step("t3_s3", 3, 4);
    finish_ramp("t3");

    // Ramp down, redirected upward after first down-step
    do_load(4'd0);
    step();
    check("t4_busy", busy_o, 1);
    wait_step("t4_d1", 2, 4);
    do_load(4'd5);
    wait_step("t4_u1", 3, 4);
    wait_step("t4_u2", 4, 4);
    wait_step("t4_u3", 5, 4);
    finish_ramp("t4");

    // Freeze mid-ramp, resume from same period count, then reset mid-ramp
    do_load(4'd9);
    step();
    wait_step("t5_s1", 6, 4);
    wait_wraps("t5_pre", 2);
    for (int c = 0; c < 5; c++) step();
    c0 = cont_o; r0 = ref_o;
    en_i = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      check($sformatf("t5_frz%0d_cont", c), cont_o, c0);
      check($sformatf("t5_frz%0d_ref", c), ref_o, r0);
      check($sformatf("t5_frz%0d_busy", c), busy_o, 1);
      check($sformatf("t5_frz%0d_wrap", c), wrap_o, 0);
    end
    en_i = 1'b1;
    wait_step("t5_s2", 7, 2);
    step();
    check("t5_busy_pre_rst", busy_o, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t5_rst_cont", cont_o, 0);
    check("t5_rst_ref", ref_o, 0);
    check("t5_rst_wrap", wrap_o, 0);
    check("t5_rst_busy", busy_o, 0);
    check("t5_rst_done", done_o, 0);
    for (int c = 0; c < 3; c++) step();
    check("t5_post_cont", cont_o, 3);
    check("t5_post_busy", busy_o, 0);
    check("t5_post_ref", ref_o, 0);

    // Equal-value load in IDLE, then load coincident with a step
    do_load(4'd3);
    step();
    wait_step("t6_a1", 1, 4);
    wait_step("t6_a2", 2, 4);
    wait_step("t6_a3", 3, 4);
    finish_ramp("t6a");
    do_load(4'd3);
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("t6_eq%0d_busy", c), busy_o, 0);
      check($sformatf("t6_eq%0d_done", c), done_o, 0);
    end
    do_load(4'd2);
    step();
    wait_step("t6_b1", 2, 4);
    finish_ramp("t6b");
    do_load(4'd4);
    step();
    check("t6_busy_up", busy_o, 1);
    wait_wraps("t6_pre", 3);
    for (int c = 0; c < 20 && cont_o != 4'd15; c++) step();
    check("t6_at_15", cont_o, 15);
    load_i = 1'b1; target_i = 4'd1;
    step();
    load_i = 1'b0;
    check("t6_coinc_ref", ref_o, 3);
    check("t6_coinc_wrap", wrap_o, 1);
    wait_step("t6_c1", 2, 4);
    wait_step("t6_c2", 1, 4);
    finish_ramp("t6c");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_ramp_ctrl.md
Name: pwm_ramp_ctrl

Overview:
Sequencer for the 4-bit PWM compare stage. Generates the free-running sawtooth count (cont_o) and the compare reference (ref_o) that drive the comparator. Moves ref_o toward a host-loaded target one LSB at a time, at period boundaries only, which gives soft-start/soft-stop without mid-period glitches. Sits between the host/config logic and the comparator.

Parameters:
WIDTH, 4, width of count, reference and target.
PRESC_W, 8, width of prescaler reload input.
STEP_PERIODS, 4, PWM periods between consecutive ref_o steps (>=1).

Ports:
clk  input  1  system clock; single clock domain.
reset  input  1  synchronous, active-high reset.
en_i  input  1  run enable; low freezes prescaler, counter, period counter and ramp.
presc_i  input  PRESC_W  counter advances once every presc_i+1 enabled clocks.
target_i  input  WIDTH  requested duty reference.
load_i  input  1  one-cycle strobe; captures target_i.
cont_o  output  WIDTH  sawtooth count to comparator.
ref_o  output  WIDTH  current reference to comparator.
wrap_o  output  1  one-cycle pulse, high in the cycle cont_o first shows 0 after 2^WIDTH-1.
busy_o  output  1  high while ramping (state RAMP).
done_o  output  1  one-cycle pulse when ramp reaches target.

Behaviour:
- Reset (synchronous, active-high): cont_o=0, ref_o=0, tgt=0, prescaler=0, period counter=0, state IDLE, wrap_o=0, busy_o=0, done_o=0. Reset takes priority over every other input, including mid-ramp.
- Prescaler: while en_i=1, presc_cnt increments each clock. When presc_cnt>=presc_i, tick=1 and presc_cnt clears. The >= test handles presc_i lowered on the fly. presc_i=0 gives a tick every enabled clock.
- Counter: on tick, cont_o<=cont_o+1 modulo 2^WIDTH. The 15->0 transition sets wrap_o=1 for exactly that one registered cycle.
- en_i=0: all state holds. wrap_o and done_o are 0. load_i is still accepted.
- Target register: load_i=1 sets tgt<=target_i on the next clock. tgt is internal.
- Period counter: counts 0..STEP_PERIODS-1 on each wrap while in RAMP, then clears. It is cleared on entry to IDLE. Width is max(1, clog2(STEP_PERIODS)).
- Step event: a wrap with period counter==STEP_PERIODS-1 while in RAMP. On a step, ref_o<=ref_o+1 if ref_o<tgt, else ref_o-1 if ref_o>tgt. ref_o changes only in the cycle wrap_o rises, so the comparator sees a constant reference within each period.
- FSM (2 states):
  - IDLE: busy_o=0. When tgt!=ref_o, go to RAMP.
  - RAMP: busy_o=1. When tgt==ref_o (checked every cycle), go to IDLE and pulse done_o=1 for one cycle on that transition.
- Simultaneous events:
  - load_i in the same cycle as a step: the step uses the old tgt; the new tgt governs from the next cycle.
  - load_i during RAMP: the ramp redirects toward the new tgt and the period counter is not cleared.
  - Load of a value equal to ref_o while in IDLE: no busy_o, no done_o.
  - Load that makes tgt==ref_o during RAMP: RAMP->IDLE with done_o.
- Arithmetic: ref_o never overflows or underflows, because steps only move toward tgt, which lies within 0..2^WIDTH-1.
- Latency: load_i to busy_o = 2 clocks (tgt register, then FSM).

Test Plan:
1. Reset, then en_i=1, presc_i=0 -> cont_o counts 0,1,...,15,0 one per clock. wrap_o high only in the cycle cont_o returns to 0 (clock 16). ref_o=0, busy_o=0.
2. presc_i=2, en_i=1 -> cont_o advances every 3 clocks and wrap_o recurs every 48 clocks. Change presc_i to 0 when presc_cnt=2 -> immediate tick, then 1/clock.
3. presc_i=0, STEP_PERIODS=4, load_i with target_i=3 from ref_o=0 -> busy_o=1 two clocks later. ref_o steps 0->1->2->3 at the 4th, 8th and 12th wraps, each coinciding with wrap_o. done_o pulses once the cycle after ref_o=3, then busy_o=0.
4. Ramp from ref_o=3 toward 0; after the first down-step (ref_o=2), load target_i=5 -> next step is 2->3 and continues to 5, followed by a single done_o.
5. Mid-ramp en_i=0 for 20 clocks -> cont_o, ref_o and busy_o are frozen, with no wrap_o. Resume -> the ramp continues from the same period count. Assert reset mid-ramp -> all outputs 0 on the next clock.
6. In IDLE with ref_o=3, load target_i=3 -> busy_o and done_o stay 0. load_i coincident with a step (target_i=1 while ramping 2->4) -> ref_o goes to 3 on that step, then ramps down to 1.
